// File: rtl/knight_anim_seq.sv
// rtl/knight_anim_seq.sv - knight animation sequencer, attack hitbox and hurt/death flags
module knight_anim_seq #(
  parameter int HOLD_FRAMES  = 4,
  parameter int ATK_REACH    = 40,
  parameter int ATK_HALF_H   = 16,
  parameter int KNIGHT_HALF  = 15,
  parameter int HURT_FRAMES  = 32,
  parameter int ATK_COOLDOWN = 8
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [3:0] Player_Status,
  input  logic       Inverse,
  input  logic [9:0] PlayerX,
  input  logic [9:0] PlayerY,
  input  logic [3:0] Player_Life,
  output logic [2:0] Anim_Set,
  output logic [2:0] Anim_Frame,
  output logic       Sprite_Mirror,
  output logic       Attack_Active,
  output logic [9:0] Hit_X_Min,
  output logic [9:0] Hit_X_Max,
  output logic [9:0] Hit_Y_Min,
  output logic [9:0] Hit_Y_Max,
  output logic       Hurt_Flash,
  output logic       Dead_Done
);

  // Counter widths; each kept at least wide enough for the logic that slices it.
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int CW = (ATK_COOLDOWN > 0) ? $clog2(ATK_COOLDOWN + 1) : 1;
  localparam int UW = ($clog2(HURT_FRAMES + 1) > 3) ? $clog2(HURT_FRAMES + 1) : 3;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
  localparam logic [CW-1:0] COOL_LOAD = CW'(ATK_COOLDOWN);
  localparam logic [UW-1:0] HURT_LOAD = UW'(HURT_FRAMES);

  // Animation states double as the Anim_Set encoding.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WALK   = 3'd1;
  localparam logic [2:0] ST_JUMP   = 3'd2;
  localparam logic [2:0] ST_FALL   = 3'd3;
  localparam logic [2:0] ST_ATTACK = 3'd4;
  localparam logic [2:0] ST_DEAD   = 3'd5;

  // Hitbox geometry; intermediates are signed and wide enough for 1023+reach.
  localparam logic signed [11:0] NEAR_OFF = 12'(KNIGHT_HALF + 1);
  localparam logic signed [11:0] FAR_OFF  = 12'(KNIGHT_HALF + ATK_REACH);
  localparam logic signed [11:0] UP_OFF   = 12'(ATK_HALF_H);
  localparam logic signed [11:0] DOWN_OFF = 12'(ATK_HALF_H - 1);
  localparam logic signed [11:0] X_LAST   = 12'sd639;
  localparam logic signed [11:0] Y_LAST   = 12'sd479;

  logic [2:0]      state_q, state_d;
  logic [2:0]      frame_q, frame_d, frame_adv;
  logic [2:0]      status_eff;
  logic [HW-1:0]   hold_q, hold_d;
  logic            hold_wrap;
  logic            attack_done;
  logic [CW-1:0]   cool_q, cool_d;
  logic            load_cool;
  logic            face_q, face_d;
  logic            attack_entry;
  logic [UW-1:0]   hurt_q, hurt_d;
  logic            hurt_hit;
  logic [3:0]      prev_life;
  logic            prev_valid;
  logic signed [11:0] px, py;
  logic signed [11:0] xmin_raw, xmax_raw, ymin_raw, ymax_raw;
  logic            in_range;
  logic            mirror_d, active_d, flash_d, done_d;

  // Clamp a signed intermediate into 0..hi.
  function automatic logic [9:0] sat(input logic signed [11:0] v, input logic signed [11:0] hi);
    if (v < 12'sd0) begin
      sat = 10'd0;
    end else if (v > hi) begin
      sat = hi[9:0];
    end else begin
      sat = v[9:0];
    end
  endfunction

  assign Anim_Set   = state_q;
  assign Anim_Frame = frame_q;

  // Next-state selection in priority order: death, attack completion, attack start, follow status.
  always_comb begin
    status_eff  = (Player_Status <= 4'd5) ? Player_Status[2:0] : ST_IDLE;
    hold_wrap   = (hold_q == HOLD_LAST);
    attack_done = (state_q == ST_ATTACK) && (frame_q == 3'd4) && hold_wrap;
    state_d     = state_q;
    load_cool   = 1'b0;
    if (state_q == ST_DEAD) begin
      state_d = ST_DEAD;
    end else if (status_eff == ST_DEAD) begin
      state_d = ST_DEAD;
    end else if (state_q == ST_ATTACK) begin
      if (attack_done) begin
        state_d   = (status_eff == ST_ATTACK) ? ST_IDLE : status_eff;
        load_cool = 1'b1;
      end
    end else if (status_eff == ST_ATTACK) begin
      if (cool_q == '0) begin
        state_d = ST_ATTACK;
      end
    end else begin
      state_d = status_eff;
    end
  end

  // Frame advance on hold wrap: loop, stop on last, or one-shot depending on the set.
  always_comb begin
    frame_adv = frame_q;
    if (hold_wrap) begin
      case (state_q)
        ST_IDLE:          frame_adv = (frame_q == 3'd3) ? 3'd0 : frame_q + 3'd1;
        ST_WALK:          frame_adv = (frame_q == 3'd5) ? 3'd0 : frame_q + 3'd1;
        ST_JUMP, ST_FALL: frame_adv = (frame_q == 3'd1) ? 3'd1 : frame_q + 3'd1;
        ST_ATTACK:        frame_adv = (frame_q == 3'd4) ? 3'd4 : frame_q + 3'd1;
        ST_DEAD:          frame_adv = (frame_q == 3'd7) ? 3'd7 : frame_q + 3'd1;
        default:          frame_adv = 3'd0;
      endcase
    end
    if (state_d != state_q) begin
      frame_d = 3'd0;
      hold_d  = '0;
    end else begin
      frame_d = frame_adv;
      hold_d  = hold_wrap ? '0 : hold_q + HW'(1);
    end
  end

  // Cooldown, facing latch and mirror selection.
  always_comb begin
    if (load_cool) begin
      cool_d = COOL_LOAD;
    end else if ((state_q != ST_ATTACK) && (cool_q != '0)) begin
      cool_d = cool_q - CW'(1);
    end else begin
      cool_d = cool_q;
    end
    attack_entry = (state_d == ST_ATTACK) && (state_q != ST_ATTACK);
    face_d       = attack_entry ? Inverse : face_q;
    mirror_d     = (state_d == ST_ATTACK) ? face_d : Inverse;
  end

  // Hitbox raw bounds, reachability and validity for the coming frame.
  always_comb begin
    px = $signed({2'b00, PlayerX});
    py = $signed({2'b00, PlayerY});
    if (face_d) begin
      xmax_raw = px - NEAR_OFF;
      xmin_raw = px - FAR_OFF;
    end else begin
      xmin_raw = px + NEAR_OFF;
      xmax_raw = px + FAR_OFF;
    end
    ymin_raw = py - UP_OFF;
    ymax_raw = py + DOWN_OFF;
    in_range = (xmax_raw >= 12'sd0) && (xmin_raw <= X_LAST);
    active_d = (state_d == ST_ATTACK) && (frame_d >= 3'd1) && (frame_d <= 3'd3) && in_range;
  end

  // Hurt window reload on life loss, blink from counter bit 2, death completion.
  always_comb begin
    hurt_hit = prev_valid && (Player_Life < prev_life);
    if (hurt_hit) begin
      hurt_d = HURT_LOAD;
    end else if (hurt_q != '0) begin
      hurt_d = hurt_q - UW'(1);
    end else begin
      hurt_d = hurt_q;
    end
    flash_d = (hurt_d != '0) && hurt_d[2] && (state_d != ST_DEAD);
    done_d  = Dead_Done || ((state_q == ST_DEAD) && (frame_q == 3'd7) && hold_wrap);
  end

  // Animation state, frame index and hold counter.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      frame_q <= 3'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
    end
  end

  // Cooldown counter and facing latched at attack entry.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      cool_q <= '0;
      face_q <= 1'b0;
    end else begin
      cool_q <= cool_d;
      face_q <= face_d;
    end
  end

  // Life tracking; the first tick after reset only seeds prev_life.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      hurt_q     <= '0;
      prev_life  <= 4'd0;
      prev_valid <= 1'b0;
    end else begin
      hurt_q     <= hurt_d;
      prev_life  <= Player_Life;
      prev_valid <= 1'b1;
    end
  end

  // Registered status flags.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      Sprite_Mirror <= 1'b0;
      Attack_Active <= 1'b0;
      Hurt_Flash    <= 1'b0;
      Dead_Done     <= 1'b0;
    end else begin
      Sprite_Mirror <= mirror_d;
      Attack_Active <= active_d;
      Hurt_Flash    <= flash_d;
      Dead_Done     <= done_d;
    end
  end

  // Hitbox bounds update only while the hitbox is valid, otherwise hold.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      Hit_X_Min <= 10'd0;
      Hit_X_Max <= 10'd0;
      Hit_Y_Min <= 10'd0;
      Hit_Y_Max <= 10'd0;
    end else if (active_d) begin
      Hit_X_Min <= sat(xmin_raw, X_LAST);
      Hit_X_Max <= sat(xmax_raw, X_LAST);
      Hit_Y_Min <= sat(ymin_raw, Y_LAST);
      Hit_Y_Max <= sat(ymax_raw, Y_LAST);
    end
  end

endmodule
